// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision add/sub front end.
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = 27;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam int EXP_BIAS = 127;

    // exp holds the effective exponent (1 for zero/denormal encodings).
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              is_nan;
        logic              is_inf;
        logic              is_zero;
    } unpacked_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational split of an IEEE 754 single into sign, effective exponent,
// 27-bit mantissa (headroom, hidden, fraction, sticky) and class flags.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0] op_i,
    output unpacked_t   unp_o
);

    logic [EXP_W-1:0]  exp_raw;
    logic [FRAC_W-1:0] frac;
    logic              exp_zero;
    logic              exp_ones;
    logic              frac_zero;

    always_comb begin
        exp_raw   = op_i[30:23];
        frac      = op_i[22:0];
        exp_zero  = (exp_raw == '0);
        exp_ones  = (exp_raw == EXP_MAX);
        frac_zero = (frac == '0);

        unp_o.sign    = op_i[31];
        unp_o.exp     = exp_zero ? 8'd1 : exp_raw;
        unp_o.mant    = {2'b00, ~exp_zero, frac, 1'b0};
        unp_o.is_nan  = exp_ones & ~frac_zero;
        unp_o.is_inf  = exp_ones & frac_zero;
        unp_o.is_zero = exp_zero & frac_zero;
    end

endmodule

// File: rtl/fp_unpack_align.sv
// FP add/sub front end: unpack, magnitude swap, iterative sticky right-align
// of the smaller mantissa, and a held output bundle for the normalize stage.
module fp_unpack_align
    import fp_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] mant_big,
    output logic [MANT_W-1:0] mant_small,
    output logic [EXP_W-1:0]  exp_result,
    output logic              result_sign,
    output logic              eff_sub,
    output logic              is_nan,
    output logic              is_inf,
    output logic              is_zero_op,
    output state_t            dbg_state
);

    localparam int STEP_C = (SHIFT_STEP > MANT_W) ? MANT_W :
                            ((SHIFT_STEP < 1) ? 1 : SHIFT_STEP);
    localparam logic [4:0]      STEP_W  = 5'(STEP_C);
    localparam logic [4:0]      REM_MAX = 5'(MANT_W);
    localparam logic [MANT_W:0] ONE_W   = {{MANT_W{1'b0}}, 1'b1};

    unpacked_t unp_a;
    unpacked_t unp_b;

    fp_unpack u_unpack_a (.op_i(a), .unp_o(unp_a));
    fp_unpack u_unpack_b (.op_i(b), .unp_o(unp_b));

    state_t            state_q, state_d;
    logic [4:0]        rem_q, rem_d;
    logic [MANT_W-1:0] mb_q, mb_d;
    logic [MANT_W-1:0] ms_q, ms_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              sign_q, sign_d;
    logic              eff_q, eff_d;
    logic              nan_q, nan_d;
    logic              inf_q, inf_d;
    logic              zero_q, zero_d;

    // Operand selection and special-value classification for the load.
    logic              sb_eff;
    logic              a_big;
    logic              big_sign;
    logic [EXP_W-1:0]  big_exp;
    logic [EXP_W-1:0]  small_exp;
    logic [MANT_W-1:0] big_mant;
    logic [MANT_W-1:0] small_mant;
    logic [EXP_W-1:0]  diff;
    logic              any_special;
    logic [4:0]        rem_init;
    logic              eff_in;
    logic              nan_in;
    logic              inf_in;
    logic              zero_in;
    logic              sign_in;

    always_comb begin
        sb_eff     = unp_b.sign ^ sub;
        a_big      = (a[30:0] >= b[30:0]);
        big_sign   = a_big ? unp_a.sign : sb_eff;
        big_exp    = a_big ? unp_a.exp  : unp_b.exp;
        small_exp  = a_big ? unp_b.exp  : unp_a.exp;
        big_mant   = a_big ? unp_a.mant : unp_b.mant;
        small_mant = a_big ? unp_b.mant : unp_a.mant;
        diff       = big_exp - small_exp;

        any_special = unp_a.is_nan | unp_b.is_nan | unp_a.is_inf | unp_b.is_inf;
        rem_init    = any_special ? 5'd0 :
                      ((diff > 8'(MANT_W)) ? REM_MAX : diff[4:0]);

        eff_in  = unp_a.sign ^ sb_eff;
        nan_in  = unp_a.is_nan | unp_b.is_nan | (unp_a.is_inf & unp_b.is_inf & eff_in);
        inf_in  = ~nan_in & (unp_a.is_inf | unp_b.is_inf);
        zero_in = unp_a.is_zero & unp_b.is_zero;

        if (nan_in) begin
            sign_in = big_sign;
        end else if (unp_a.is_inf) begin
            sign_in = unp_a.sign;
        end else if (unp_b.is_inf) begin
            sign_in = sb_eff;
        end else if (zero_in) begin
            sign_in = unp_a.sign & sb_eff;
        end else begin
            sign_in = big_sign;
        end
    end

    // One alignment step: shift by up to STEP_C, fold shifted-out bits into bit 0.
    logic [4:0]        step;
    logic [MANT_W:0]   mask_w;
    logic              lost;
    logic [MANT_W-1:0] shifted;
    logic [MANT_W-1:0] shifted_st;

    always_comb begin
        step       = (rem_q > STEP_W) ? STEP_W : rem_q;
        mask_w     = (ONE_W << step) - ONE_W;
        lost       = |(ms_q & mask_w[MANT_W-1:0]);
        shifted    = ms_q >> step;
        shifted_st = {shifted[MANT_W-1:1], shifted[0] | lost};
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mb_d    = mb_q;
        ms_d    = ms_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        eff_d   = eff_q;
        nan_d   = nan_q;
        inf_d   = inf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ALIGN;
                    rem_d   = rem_init;
                    mb_d    = big_mant;
                    ms_d    = small_mant;
                    exp_d   = big_exp;
                    sign_d  = sign_in;
                    eff_d   = eff_in;
                    nan_d   = nan_in;
                    inf_d   = inf_in;
                    zero_d  = zero_in;
                end
            end
            ALIGN: begin
                if (rem_q == 5'd0) begin
                    state_d = OUT;
                end else begin
                    ms_d  = shifted_st;
                    rem_d = rem_q - step;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            mb_q    <= '0;
            ms_q    <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            eff_q   <= 1'b0;
            nan_q   <= 1'b0;
            inf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mb_q    <= mb_d;
            ms_q    <= ms_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            eff_q   <= eff_d;
            nan_q   <= nan_d;
            inf_q   <= inf_d;
            zero_q  <= zero_d;
        end
    end

    // Input side: ready only in IDLE. Output side: bundle valid in OUT, held until out_ready.
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == OUT);
    assign mant_big    = mb_q;
    assign mant_small  = ms_q;
    assign exp_result  = exp_q;
    assign result_sign = sign_q;
    assign eff_sub     = eff_q;
    assign is_nan      = nan_q;
    assign is_inf      = inf_q;
    assign is_zero_op  = zero_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fp_unpack_align.sv
// Self-checking bench for fp_unpack_align with a scoreboard of expected bundles.
module tb_fp_unpack_align;
    import fp_pkg::*;

    localparam int STEP = 4;
    localparam int BW   = 67;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] mant_big;
    logic [26:0] mant_small;
    logic [7:0]  exp_result;
    logic        result_sign;
    logic        eff_sub;
    logic        is_nan;
    logic        is_inf;
    logic        is_zero_op;
    state_t      dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [BW-1:0] exp_q[$];
    int            lat_q[$];

    fp_unpack_align #(.SHIFT_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .mant_big(mant_big), .mant_small(mant_small), .exp_result(exp_result),
        .result_sign(result_sign), .eff_sub(eff_sub), .is_nan(is_nan),
        .is_inf(is_inf), .is_zero_op(is_zero_op), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: bit-serial sticky shift, bundle {mb, ms, exp, sign, eff, nan, inf, zero}.
    function automatic logic [BW-1:0] model(input logic [31:0] av, input logic [31:0] bv,
                                             input logic sv, output int lat);
        logic sa, sb, es, nan, inf, zero, sg, abig;
        logic [7:0] ea, eb, ebig, esml;
        logic [22:0] fa, fb;
        logic na, nb, ia, ib, za, zb;
        logic [26:0] ma, mb_m, mbig, msml;
        int d, dc;
        sa = av[31]; sb = bv[31] ^ sv;
        ea = av[30:23]; eb = bv[30:23];
        fa = av[22:0]; fb = bv[22:0];
        na = (ea == 8'hFF) && (fa != 0); nb = (eb == 8'hFF) && (fb != 0);
        ia = (ea == 8'hFF) && (fa == 0); ib = (eb == 8'hFF) && (fb == 0);
        za = (ea == 0) && (fa == 0);     zb = (eb == 0) && (fb == 0);
        ma   = {2'b00, (ea != 0), fa, 1'b0};
        mb_m = {2'b00, (eb != 0), fb, 1'b0};
        abig = (av[30:0] >= bv[30:0]);
        mbig = abig ? ma : mb_m;
        msml = abig ? mb_m : ma;
        ebig = abig ? ((ea == 0) ? 8'd1 : ea) : ((eb == 0) ? 8'd1 : eb);
        esml = abig ? ((eb == 0) ? 8'd1 : eb) : ((ea == 0) ? 8'd1 : ea);
        d = int'(ebig) - int'(esml);
        if (na || nb || ia || ib) d = 0;
        dc = (d > 27) ? 27 : d;
        for (int i = 0; i < dc; i++) msml = (msml >> 1) | {26'd0, msml[0]};
        es   = sa ^ sb;
        nan  = na | nb | (ia & ib & es);
        inf  = ~nan & (ia | ib);
        zero = za & zb;
        sg   = abig ? sa : sb;
        if (!nan && ia) sg = sa;
        else if (!nan && ib) sg = sb;
        else if (!nan && zero) sg = sa & sb;
        lat = 2 + (dc + STEP - 1) / STEP;
        return {mbig, msml, ebig, sg, es, nan, inf, zero};
    endfunction

    function automatic logic [BW-1:0] sign_mask(input logic [BW-1:0] e);
        logic [BW-1:0] m;
        m = '1;
        if (e[2]) m[4] = 1'b0;
        return m;
    endfunction

    task automatic push_model(input logic [31:0] av, input logic [31:0] bv, input logic sv);
        int l;
        logic [BW-1:0] e;
        e = model(av, bv, sv, l);
        exp_q.push_back(e);
        lat_q.push_back(l);
    endtask

    // Drives one operation through the full handshake; lat = -1 if out_valid never rose.
    task automatic drive_op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                            output logic [BW-1:0] obs, output int lat);
        int cyc;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a = av; b = bv; sub = sv; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        obs = {mant_big, mant_small, exp_result, result_sign, eff_sub, is_nan, is_inf, is_zero_op};
        lat = out_valid ? cyc : -1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
        else n_pass++;
        n_checks++;
        if ({mant_big, mant_small, exp_result} !== 62'd0)
            $display("FAIL reset_data: got %h/%h/%h want 0", mant_big, mant_small, exp_result);
        else n_pass++;
        n_checks++;
        if ({result_sign, eff_sub, is_nan, is_inf, is_zero_op} !== 5'd0)
            $display("FAIL reset_flags: got %b want 00000",
                     {result_sign, eff_sub, is_nan, is_inf, is_zero_op});
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [31:0] ta[6] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                               32'h00800000, 32'hC0400000};
        logic [31:0] tb[6] = '{32'h3F800000, 32'h3F000000, 32'h2B800000, 32'h40000000,
                               32'h00400000, 32'h3F800000};
        logic        ts[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [26:0] tms[6] = '{27'h1000000, 27'h0800000, 27'h0000001, 27'h0800000,
                                27'h0800000, 27'h0800000};
        logic [7:0]  ter[6] = '{8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h01, 8'h80};
        logic [1:0]  tse[6] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11};
        int          tl[6]  = '{2, 3, 9, 3, 2, 3};
        logic [BW-1:0] obs, e;
        int lat, el;
        for (int i = 0; i < 6; i++) begin
            push_model(ta[i], tb[i], ts[i]);
            drive_op(ta[i], tb[i], ts[i], obs, lat);
            e  = exp_q.pop_front();
            el = lat_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL dir%0d_bundle: got %h want %h", i, obs, e);
            else n_pass++;
            n_checks++;
            if (lat !== tl[i] || lat !== el)
                $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tl[i]);
            else n_pass++;
            n_checks++;
            if (obs[39:13] !== tms[i] || obs[12:5] !== ter[i] || obs[4:3] !== tse[i])
                $display("FAIL dir%0d_fields: got ms=%h exp=%h se=%b want ms=%h exp=%h se=%b",
                         i, obs[39:13], obs[12:5], obs[4:3], tms[i], ter[i], tse[i]);
            else n_pass++;
        end
    endtask

    task automatic test_specials();
        logic [31:0] ta[9] = '{32'h7FC00000, 32'h7F800000, 32'h7F800000, 32'hFF800000,
                               32'h3F800000, 32'h80000000, 32'h80000000, 32'h00000000,
                               32'h7F800000};
        logic [31:0] tb[9] = '{32'h3F800000, 32'h7F800000, 32'hFF800000, 32'h3F800000,
                               32'h7F800000, 32'h80000000, 32'h80000000, 32'h80000000,
                               32'h7F800000};
        logic        ts[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  tf[9] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001,
                               3'b001, 3'b010};
        logic        tsg[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [BW-1:0] obs, e, m;
        int lat, el;
        for (int i = 0; i < 9; i++) begin
            push_model(ta[i], tb[i], ts[i]);
            drive_op(ta[i], tb[i], ts[i], obs, lat);
            e  = exp_q.pop_front();
            el = lat_q.pop_front();
            m  = sign_mask(e);
            n_checks++;
            if ((obs & m) !== (e & m)) $display("FAIL spc%0d_bundle: got %h want %h", i, obs, e);
            else n_pass++;
            n_checks++;
            if (obs[2:0] !== tf[i] || lat !== 2 || el !== 2)
                $display("FAIL spc%0d_flags: got nan/inf/zero=%b lat=%0d want %b lat=2",
                         i, obs[2:0], lat, tf[i]);
            else n_pass++;
            if (!tf[i][2]) begin
                n_checks++;
                if (obs[4] !== tsg[i]) $display("FAIL spc%0d_sign: got %b want %b", i, obs[4], tsg[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_hold_out();
        logic [BW-1:0] cap, now_b, e;
        int cyc, el;
        push_model(32'h3F800000, 32'h3F000000, 1'b0);
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3F000000; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        cap = {mant_big, mant_small, exp_result, result_sign, eff_sub, is_nan, is_inf, is_zero_op};
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        n_checks++;
        if (cap !== e || cyc !== el) $display("FAIL hold_bundle: got %h lat %0d want %h lat %0d", cap, cyc, e, el);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            now_b = {mant_big, mant_small, exp_result, result_sign, eff_sub, is_nan, is_inf, is_zero_op};
            n_checks++;
            if (now_b !== cap || out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL hold_stable%0d: got %h v=%b r=%b want %h v=1 r=0",
                         i, now_b, out_valid, in_ready, cap);
            else n_pass++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL hold_release: got r=%b v=%b want r=1 v=0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_align();
        int seen;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h35800000; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (dbg_state !== ALIGN) $display("FAIL abort_in_align: got %0d want %0d", dbg_state, ALIGN);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (dbg_state !== IDLE || in_ready !== 1'b1 || out_valid !== 1'b0 || mant_small !== 27'd0)
            $display("FAIL abort_state: got st=%0d r=%b v=%b ms=%h want IDLE r=1 v=0 ms=0",
                     dbg_state, in_ready, out_valid, mant_small);
        else n_pass++;
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (seen !== 0) $display("FAIL abort_no_output: got %0d valid cycles want 0", seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] av, bv;
        logic sv;
        logic [BW-1:0] obs, e, m;
        int lat, el;
        for (int i = 0; i < 20; i++) begin
            av = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
            bv = {1'($urandom_range(0, 1)), 8'($urandom_range(95, 155)), 23'($urandom)};
            if ($urandom_range(0, 5) == 0) bv[30:23] = 8'd0;
            sv = 1'($urandom_range(0, 1));
            push_model(av, bv, sv);
            drive_op(av, bv, sv, obs, lat);
            e  = exp_q.pop_front();
            el = lat_q.pop_front();
            m  = sign_mask(e);
            n_checks++;
            if ((obs & m) !== (e & m) || lat !== el)
                $display("FAIL b2b%0d: a=%h b=%h sub=%b got %h lat %0d want %h lat %0d",
                         i, av, bv, sv, obs, lat, e, el);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0;
        test_reset();
        test_directed();
        test_specials();
        test_hold_out();
        test_reset_mid_align();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
